energy_frame_rx: RTL

- Receiving end of the converter's serial telemetry link. Deserializes a UART 8N1 stream of 4-byte frames: sync 0xA5, voltage code, current code, checksum.
- Validates each frame and holds the last good voltage and current codes for the data and display logic.
- Sits between the rx_serial pin and the downstream data/display path.

---
 rtl/energy_frame_rx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/energy_frame_rx.sv
// Serial telemetry receiver: UART 8N1 deserializer plus a 4-byte frame checker (A5, v, c, csum).
// Define ENERGY_POWER_CALC_EN to register power_out = volt*curr; otherwise power_out is tied to 0.
module energy_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_serial,
  output logic [7:0]  volt_out,
  output logic [7:0]  curr_out,
  output logic [15:0] power_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
  localparam int unsigned ToCycles  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW        = $clog2(ToCycles + 1);
  localparam logic [CW-1:0] HalfCnt = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LastCnt = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] ToLast  = TW'(ToCycles - 1);
  localparam logic [7:0]    SyncByte = 8'hA5;

  typedef enum logic [1:0] {BitIdle, BitStart, BitData, BitStop} bit_st_e;
  typedef enum logic [1:0] {FrHunt, FrVolt, FrCurr, FrCsum} fr_st_e;

  // Two-flop synchronizer; resets to the idle (high) line level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  bit_st_e       bit_st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          byte_ok_q;
  logic          stop_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_st_q   <= BitIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      byte_ok_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      byte_ok_q  <= 1'b0;
      stop_err_q <= 1'b0;
      case (bit_st_q)
        BitIdle: begin
          if (!rx_s_q) begin
            bit_st_q <= BitStart;
            cnt_q    <= '0;
          end
        end
        BitStart: begin
          if (cnt_q == HalfCnt) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            // A high line at mid-start is a glitch, not a byte.
            bit_st_q <= rx_s_q ? BitIdle : BitData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BitData: begin
          if (cnt_q == LastCnt) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) bit_st_q <= BitStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BitStop: begin
          if (cnt_q == LastCnt) begin
            cnt_q    <= '0;
            bit_st_q <= BitIdle;
            if (rx_s_q) byte_ok_q  <= 1'b1;
            else        stop_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: bit_st_q <= BitIdle;
      endcase
    end
  end

  fr_st_e        fr_st_q;
  logic [7:0]    v_q, c_q;
  logic [7:0]    volt_q, curr_q;
  logic          valid_q, err_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    csum_exp;
  logic          frame_good;

  assign csum_exp   = SyncByte + v_q + c_q;
  assign frame_good = byte_ok_q && (fr_st_q == FrCsum) && (shift_q == csum_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fr_st_q  <= FrHunt;
      v_q      <= '0;
      c_q      <= '0;
      volt_q   <= '0;
      curr_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (stop_err_q) begin
        err_q    <= 1'b1;
        fr_st_q  <= FrHunt;
        to_cnt_q <= '0;
      end else if (byte_ok_q) begin
        to_cnt_q <= '0;
        case (fr_st_q)
          FrHunt: if (shift_q == SyncByte) fr_st_q <= FrVolt;
          FrVolt: begin
            v_q     <= shift_q;
            fr_st_q <= FrCurr;
          end
          FrCurr: begin
            c_q     <= shift_q;
            fr_st_q <= FrCsum;
          end
          FrCsum: begin
            if (frame_good) begin
              volt_q  <= v_q;
              curr_q  <= c_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            fr_st_q <= FrHunt;
          end
          default: fr_st_q <= FrHunt;
        endcase
      end else if (fr_st_q != FrHunt) begin
        // Only idle line time counts toward the timeout; any start bit restarts it.
        if (bit_st_q != BitIdle) begin
          to_cnt_q <= '0;
        end else if (to_cnt_q == ToLast) begin
          err_q    <= 1'b1;
          fr_st_q  <= FrHunt;
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

`ifdef ENERGY_POWER_CALC_EN
  logic [15:0] power_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      power_q <= '0;
    end else if (frame_good) begin
      power_q <= {8'h00, v_q} * {8'h00, c_q};
    end
  end

  assign power_out = power_q;
`else
  assign power_out = 16'h0000;
`endif

  assign volt_out    = volt_q;
  assign curr_out    = curr_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = (fr_st_q != FrHunt);

endmodule
